// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared encodings for the forwarding / load-use hazard unit
package fwd_pkg;
  localparam int         FWD_NONE = 0;
  localparam logic [4:0] X0       = 5'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;
endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - one-source forward select, nearest producer stage wins
module fwd_select
  import fwd_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int SELW       = 2
) (
  input  logic [4:0]              i_rs,
  input  logic [NUM_STAGES*5-1:0] i_stage_rd,
  input  logic [NUM_STAGES-1:0]   i_stage_we,
  output logic [SELW-1:0]         o_sel
);

  // Walk from the farthest stage inward so the nearest match overwrites.
  always_comb begin
    o_sel = SELW'(FWD_NONE);
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (i_stage_we[k] && (i_stage_rd[5*k +: 5] != X0) &&
          (i_stage_rd[5*k +: 5] == i_rs))
        o_sel = SELW'(k + 1);
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// rtl/forwarding_hazard_unit.sv - EX operand forwarding plus load-use stall sequencer
module forwarding_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC    = 2,
  parameter  int NUM_STAGES = 2,
  parameter  int LOAD_LAT   = 1,
  localparam int SELW       = $clog2(NUM_STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC*5-1:0]    ex_rs,
  input  logic [NUM_STAGES*5-1:0] stage_rd,
  input  logic [NUM_STAGES-1:0]   stage_RegWrite,
  input  logic [NUM_SRC*5-1:0]    id_rs,
  input  logic                    id_valid,
  input  logic [4:0]              ex_rd,
  input  logic                    ex_MemRead,
  input  logic                    flush,
  output logic [NUM_SRC*SELW-1:0] forward,
  output logic                    stall,
  output logic [15:0]             stall_count
);

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      fwd_select #(
        .NUM_STAGES(NUM_STAGES),
        .SELW      (SELW)
      ) u_fwd_select (
        .i_rs      (ex_rs[5*g +: 5]),
        .i_stage_rd(stage_rd),
        .i_stage_we(stage_RegWrite),
        .o_sel     (forward[SELW*g +: SELW])
      );
    end
  endgenerate

  logic w_hazard;
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs[5*i +: 5] == ex_rd)
        w_hazard = 1'b1;
    end
    w_hazard = w_hazard && id_valid && ex_MemRead && (ex_rd != X0);
  end

  state_t     r_state;
  logic [3:0] r_cnt;
  state_t     w_next_state;
  logic [3:0] w_next_cnt;
  logic [15:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // The IDLE cycle that detects the hazard is itself the first stall cycle.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (flush) begin
      w_next_state = IDLE;
      w_next_cnt   = 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hazard && (LOAD_LAT > 1)) begin
            w_next_state = STALL;
            w_next_cnt   = 4'(LOAD_LAT - 1);
          end
        end
        STALL: begin
          w_next_cnt = r_cnt - 4'd1;
          if (r_cnt == 4'd1)
            w_next_state = IDLE;
        end
        default: begin
          w_next_state = IDLE;
          w_next_cnt   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    if (!rst && !flush) begin
      case (r_state)
        IDLE:    stall = w_hazard;
        STALL:   stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_count <= 16'd0;
    else if (stall && (r_stall_count != 16'hFFFF))
      r_stall_count <= r_stall_count + 16'd1;
  end

  assign stall_count = r_stall_count;

endmodule
